// File: rtl/miss_arb_pkg.sv
// Shared defaults, channel IDs and width helpers for the miss arbiter.
// No logic; latency and backpressure do not apply.
package miss_arb_pkg;
    localparam int REQ_W_DEF  = 149;
    localparam int DATA_W_DEF = 128;
    localparam int ICACHE_CH  = 0;
    localparam int DCACHE_CH  = 1;

    function automatic int calc_id_w(input int num_ch);
        return (num_ch > 2) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int calc_cnt_w(input int max_out);
        return $clog2(max_out + 1);
    endfunction
endpackage

// File: rtl/miss_id_fifo.sv
// Channel-ID FIFO tracking in-order outstanding misses; head is visible combinationally.
// Push is refused only when full without a same-cycle pop; pop on empty is ignored.
module miss_id_fifo
    import miss_arb_pkg::*;
#(
    parameter int W      = 1,
    parameter int DEPTH  = 4,
    localparam int CNT_W = calc_cnt_w(DEPTH),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [W-1:0]     i_push_dat,
    input  logic             i_pop,
    output logic [W-1:0]     o_pop_dat,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);
    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_pop_dat = r_mem[r_rd_ptr];
    assign w_pop     = i_pop && !o_empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_push    = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
    end
endmodule

// File: rtl/miss_arbiter.sv
// Arbitrates N cache-miss channels onto one memory port; request 1 cycle, response 1 cycle.
// Grants stall while the request slot is held by mem_req_ready=0 or MAX_OUT misses are outstanding.
module miss_arbiter
    import miss_arb_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int REQ_W   = REQ_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MAX_OUT = 4,
    parameter int RR_EN   = 1,
    localparam int ID_W   = calc_id_w(NUM_CH),
    localparam int CNT_W  = calc_cnt_w(MAX_OUT)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_CH-1:0]       i_ch_req_valid,
    input  logic [NUM_CH*REQ_W-1:0] i_ch_req_info,
    output logic [NUM_CH-1:0]       o_ch_req_ready,
    output logic                    o_mem_req_valid,
    output logic [REQ_W-1:0]        o_mem_req_info,
    output logic [ID_W-1:0]         o_mem_req_id,
    input  logic                    i_mem_req_ready,
    input  logic                    i_mem_rsp_valid,
    input  logic [DATA_W-1:0]       i_mem_rsp_data,
    input  logic                    i_mem_rsp_bus_error,
    output logic [NUM_CH-1:0]       o_ch_rsp_valid,
    output logic [DATA_W-1:0]       o_ch_rsp_data,
    output logic [NUM_CH-1:0]       o_ch_rsp_bus_error,
    output logic [CNT_W-1:0]        o_outstanding_cnt,
    output logic                    o_rsp_orphan_err
);
    logic              r_req_vld;
    logic [REQ_W-1:0]  r_req_info;
    logic [ID_W-1:0]   r_req_id;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [NUM_CH-1:0] r_rsp_vld;
    logic [NUM_CH-1:0] r_rsp_err;
    logic [DATA_W-1:0] r_rsp_dat;
    logic              r_orphan;

    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [ID_W-1:0]   w_fifo_head;
    logic              w_pop;
    logic              w_can_accept;
    logic              w_found;
    logic [ID_W-1:0]   w_gnt_idx;
    logic              w_grant;
    logic [NUM_CH-1:0] w_head_oh;
    int                w_idx;

    assign w_pop        = i_mem_rsp_valid && !w_fifo_empty;
    assign w_can_accept = (!r_req_vld || i_mem_req_ready) && (!w_fifo_full || w_pop);

    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_idx     = 0;
        if (RR_EN != 0) begin
            // Search starts one past the last winner so every channel gets a turn.
            for (int k = 1; k <= NUM_CH; k++) begin
                w_idx = (int'(r_rr_ptr) + k) % NUM_CH;
                if (!w_found && i_ch_req_valid[w_idx]) begin
                    w_found   = 1'b1;
                    w_gnt_idx = ID_W'(w_idx);
                end
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (!w_found && i_ch_req_valid[k]) begin
                    w_found   = 1'b1;
                    w_gnt_idx = ID_W'(k);
                end
            end
        end
    end

    assign w_grant        = w_can_accept && w_found;
    assign o_ch_req_ready = w_grant ? (NUM_CH'(1) << w_gnt_idx) : '0;
    assign w_head_oh      = NUM_CH'(1) << w_fifo_head;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req_vld  <= 1'b0;
            r_req_info <= '0;
            r_req_id   <= '0;
            r_rr_ptr   <= ID_W'(NUM_CH - 1);
        end else begin
            if (w_grant) begin
                r_req_vld  <= 1'b1;
                r_req_info <= i_ch_req_info[int'(w_gnt_idx)*REQ_W +: REQ_W];
                r_req_id   <= w_gnt_idx;
                r_rr_ptr   <= w_gnt_idx;
            end else if (i_mem_req_ready) begin
                r_req_vld  <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rsp_vld <= '0;
            r_rsp_err <= '0;
            r_rsp_dat <= '0;
            r_orphan  <= 1'b0;
        end else begin
            r_rsp_vld <= w_pop ? w_head_oh : '0;
            r_rsp_err <= (w_pop && i_mem_rsp_bus_error) ? w_head_oh : '0;
            if (w_pop) r_rsp_dat <= i_mem_rsp_data;
            if (i_mem_rsp_valid && w_fifo_empty) r_orphan <= 1'b1;
        end
    end

    miss_id_fifo #(
        .W     (ID_W),
        .DEPTH (MAX_OUT)
    ) u_id_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_push     (w_grant),
        .i_push_dat (w_gnt_idx),
        .i_pop      (w_pop),
        .o_pop_dat  (w_fifo_head),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_count    (o_outstanding_cnt)
    );

    assign o_mem_req_valid    = r_req_vld;
    assign o_mem_req_info     = r_req_info;
    assign o_mem_req_id       = r_req_id;
    assign o_ch_rsp_valid     = r_rsp_vld;
    assign o_ch_rsp_bus_error = r_rsp_err;
    assign o_ch_rsp_data      = r_rsp_dat;
    assign o_rsp_orphan_err   = r_orphan;
endmodule

// File: tb/tb_miss_arbiter.sv
// Drives a round-robin instance (index 0) and a fixed-priority instance (index 1) side by side
// and compares both every cycle against a queue-level model of the arbiter's rules.
module tb_miss_arbiter;
    localparam int REQ_W   = 149;
    localparam int DATA_W  = 128;
    localparam int MAX_OUT = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]         ch_vld    [2];
    logic [2*REQ_W-1:0] ch_info   [2];
    logic               mreq_rdy  [2];
    logic               rsp_vld   [2];
    logic [DATA_W-1:0]  rsp_dat   [2];
    logic               rsp_err   [2];
    logic [1:0]         req_rdy   [2];
    logic               mreq_vld  [2];
    logic [REQ_W-1:0]   mreq_info [2];
    logic [0:0]         mreq_id   [2];
    logic [1:0]         rsp_v     [2];
    logic [DATA_W-1:0]  rsp_d     [2];
    logic [1:0]         rsp_e     [2];
    logic [2:0]         ocnt      [2];
    logic               orph      [2];

    miss_arbiter #(.NUM_CH(2), .REQ_W(REQ_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT), .RR_EN(1)) u_rr (
        .i_clk(clk), .i_rst_n(rst_n), .i_ch_req_valid(ch_vld[0]), .i_ch_req_info(ch_info[0]),
        .o_ch_req_ready(req_rdy[0]), .o_mem_req_valid(mreq_vld[0]), .o_mem_req_info(mreq_info[0]),
        .o_mem_req_id(mreq_id[0]), .i_mem_req_ready(mreq_rdy[0]), .i_mem_rsp_valid(rsp_vld[0]),
        .i_mem_rsp_data(rsp_dat[0]), .i_mem_rsp_bus_error(rsp_err[0]), .o_ch_rsp_valid(rsp_v[0]),
        .o_ch_rsp_data(rsp_d[0]), .o_ch_rsp_bus_error(rsp_e[0]), .o_outstanding_cnt(ocnt[0]),
        .o_rsp_orphan_err(orph[0]));

    miss_arbiter #(.NUM_CH(2), .REQ_W(REQ_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT), .RR_EN(0)) u_fp (
        .i_clk(clk), .i_rst_n(rst_n), .i_ch_req_valid(ch_vld[1]), .i_ch_req_info(ch_info[1]),
        .o_ch_req_ready(req_rdy[1]), .o_mem_req_valid(mreq_vld[1]), .o_mem_req_info(mreq_info[1]),
        .o_mem_req_id(mreq_id[1]), .i_mem_req_ready(mreq_rdy[1]), .i_mem_rsp_valid(rsp_vld[1]),
        .i_mem_rsp_data(rsp_dat[1]), .i_mem_rsp_bus_error(rsp_err[1]), .o_ch_rsp_valid(rsp_v[1]),
        .o_ch_rsp_data(rsp_d[1]), .o_ch_rsp_bus_error(rsp_e[1]), .o_outstanding_cnt(ocnt[1]),
        .o_rsp_orphan_err(orph[1]));

    int n_checks = 0;
    int n_err    = 0;

    // Model: slot contents, ordered list of outstanding channel IDs, last response.
    logic              m_slot_v    [2];
    logic [REQ_W-1:0]  m_slot_info [2];
    int                m_slot_id   [2];
    int                m_rr        [2];
    int                m_list      [2][8];
    int                m_cnt       [2];
    logic              m_orph      [2];
    logic [1:0]        m_rv        [2];
    logic [1:0]        m_re        [2];
    logic [DATA_W-1:0] m_rd        [2];
    int                m_last_g    [2];

    task automatic chk(input string nm, input int d, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d t=%0t act=%0h exp=%0h", nm, d, $time, act, exp);
        end
    endtask

    function automatic logic [REQ_W-1:0] rand_info();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[REQ_W-1:0];
    endfunction

    function automatic int exp_grant(input int d);
        bit can;
        can = (!m_slot_v[d] || mreq_rdy[d]) && (m_cnt[d] < MAX_OUT || (rsp_vld[d] && m_cnt[d] > 0));
        if (!can) return -1;
        if (d == 0) begin
            for (int k = 1; k <= 2; k++)
                if (ch_vld[d][(m_rr[d] + k) % 2]) return (m_rr[d] + k) % 2;
        end else begin
            for (int c = 0; c < 2; c++)
                if (ch_vld[d][c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_slot_v[d] = 1'b0; m_slot_info[d] = '0; m_slot_id[d] = 0; m_rr[d] = 1;
            m_cnt[d] = 0; m_orph[d] = 1'b0; m_rv[d] = '0; m_re[d] = '0; m_rd[d] = '0;
            m_last_g[d] = -1;
        end
    endtask

    task automatic compare_all();
        logic [1:0] exp_rdy;
        int g;
        for (int d = 0; d < 2; d++) begin
            g = exp_grant(d);
            exp_rdy = (g < 0) ? 2'b00 : 2'(1 << g);
            chk("ch_req_ready", d, 256'(req_rdy[d]), 256'(exp_rdy));
            chk("mem_req_valid", d, 256'(mreq_vld[d]), 256'(m_slot_v[d]));
            if (m_slot_v[d]) begin
                chk("mem_req_info", d, 256'(mreq_info[d]), 256'(m_slot_info[d]));
                chk("mem_req_id", d, 256'(mreq_id[d]), 256'(m_slot_id[d]));
            end
            chk("ch_rsp_valid", d, 256'(rsp_v[d]), 256'(m_rv[d]));
            chk("ch_rsp_bus_error", d, 256'(rsp_e[d]), 256'(m_re[d]));
            chk("ch_rsp_data", d, 256'(rsp_d[d]), 256'(m_rd[d]));
            chk("outstanding_cnt", d, 256'(ocnt[d]), 256'(m_cnt[d]));
            chk("rsp_orphan_err", d, 256'(orph[d]), 256'(m_orph[d]));
        end
    endtask

    task automatic step_all();
        int g;
        int h;
        bit pop;
        for (int d = 0; d < 2; d++) begin
            g   = exp_grant(d);
            pop = rsp_vld[d] && (m_cnt[d] > 0);
            if (pop) begin
                h = m_list[d][0];
                for (int i = 0; i < 7; i++) m_list[d][i] = m_list[d][i+1];
                m_cnt[d]--;
                m_rv[d] = 2'(1 << h);
                m_re[d] = rsp_err[d] ? 2'(1 << h) : 2'b00;
                m_rd[d] = rsp_dat[d];
            end else begin
                m_rv[d] = '0;
                m_re[d] = '0;
                if (rsp_vld[d]) m_orph[d] = 1'b1;
            end
            if (g >= 0) begin
                m_list[d][m_cnt[d]] = g;
                m_cnt[d]++;
                m_slot_v[d]    = 1'b1;
                m_slot_info[d] = ch_info[d][g*REQ_W +: REQ_W];
                m_slot_id[d]   = g;
                if (d == 0) m_rr[d] = g;
            end else if (mreq_rdy[d]) begin
                m_slot_v[d] = 1'b0;
            end
            m_last_g[d] = g;
        end
    endtask

    task automatic tick();
        compare_all();
        step_all();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        @(negedge clk);
        tick();
    endtask

    task automatic drive(input logic [1:0] v, input logic rdy, input logic rv, input logic re);
        for (int d = 0; d < 2; d++) begin
            ch_vld[d] = v; mreq_rdy[d] = rdy; rsp_vld[d] = rv; rsp_err[d] = re;
            rsp_dat[d] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    initial begin
        logic [REQ_W-1:0] info0;
        logic [REQ_W-1:0] info1;
        info0 = REQ_W'('h1CD);
        info1 = REQ_W'('hAB);
        rst_n = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        for (int d = 0; d < 2; d++) ch_info[d] = {info1, info0};
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_req_ready", d, 256'(req_rdy[d]), 256'd0);
            chk("reset_mem_req_valid", d, 256'(mreq_vld[d]), 256'd0);
            chk("reset_mem_req_info", d, 256'(mreq_info[d]), 256'd0);
            chk("reset_rsp_valid", d, 256'(rsp_v[d]), 256'd0);
            chk("reset_rsp_data", d, 256'(rsp_d[d]), 256'd0);
            chk("reset_cnt", d, 256'(ocnt[d]), 256'd0);
            chk("reset_orphan", d, 256'(orph[d]), 256'd0);
        end
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single ch1 request with memory stalled.
        drive(2'b10, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("ch1_ready", d, 256'(req_rdy[d]), 256'h2);
        tick();
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("ch1_mem_valid", d, 256'(mreq_vld[d]), 256'd1);
            chk("ch1_mem_id", d, 256'(mreq_id[d]), 256'd1);
            chk("ch1_mem_info", d, 256'(mreq_info[d]), 256'hAB);
            chk("ch1_cnt", d, 256'(ocnt[d]), 256'd1);
        end
        tick();
        drive(2'b00, 1'b1, 1'b0, 1'b0);
        cyc();
        drive(2'b00, 1'b1, 1'b1, 1'b0);
        cyc();
        drive(2'b00, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("ch1_rsp_valid", d, 256'(rsp_v[d]), 256'h2);
            chk("ch1_rsp_cnt", d, 256'(ocnt[d]), 256'd0);
        end
        tick();

        // Both channels held valid, no responses: fill to MAX_OUT.
        drive(2'b11, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_grant_seq", 0, 256'(req_rdy[0]), (i % 2 == 0) ? 256'h1 : 256'h2);
            chk("fp_grant_seq", 1, 256'(req_rdy[1]), 256'h1);
            tick();
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("full_stall", d, 256'(req_rdy[d]), 256'd0);
            chk("full_cnt", d, 256'(ocnt[d]), 256'd4);
        end
        tick();

        // Full FIFO: a response in the grant cycle frees the entry.
        drive(2'b11, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("full_pop_grant", d, 256'(req_rdy[d]), 256'h1);
            chk("full_pop_cnt", d, 256'(ocnt[d]), 256'd4);
        end
        tick();
        drive(2'b00, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("full_pop_rsp", d, 256'(rsp_v[d]), 256'h1);
            chk("full_pop_cnt2", d, 256'(ocnt[d]), 256'd4);
        end
        tick();
        for (int i = 0; i < 3; i++) cyc();
        drive(2'b00, 1'b1, 1'b0, 1'b0);
        cyc();
        cyc();

        // ch0 then ch1, second response carries a bus error.
        drive(2'b01, 1'b1, 1'b0, 1'b0);
        cyc();
        drive(2'b10, 1'b1, 1'b0, 1'b0);
        cyc();
        drive(2'b00, 1'b1, 1'b0, 1'b0);
        cyc();
        cyc();
        drive(2'b00, 1'b1, 1'b1, 1'b0);
        cyc();
        drive(2'b00, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("err_rsp0", d, 256'(rsp_v[d]), 256'h1);
        tick();
        drive(2'b00, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("err_rsp1", d, 256'(rsp_v[d]), 256'h2);
            chk("err_rsp1_err", d, 256'(rsp_e[d]), 256'h2);
            chk("err_cnt", d, 256'(ocnt[d]), 256'd0);
        end
        tick();

        // Orphan response.
        drive(2'b00, 1'b1, 1'b1, 1'b0);
        cyc();
        drive(2'b00, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("orphan_no_rsp", d, 256'(rsp_v[d]), 256'd0);
            chk("orphan_set", d, 256'(orph[d]), 256'd1);
        end
        tick();
        cyc();
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("orphan_sticky", d, 256'(orph[d]), 256'd1);
        tick();

        // Random traffic with one asynchronous reset in the middle.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                #2 rst_n = 1'b0;
                #1;
                for (int d = 0; d < 2; d++) begin
                    chk("async_rst_mem_valid", d, 256'(mreq_vld[d]), 256'd0);
                    chk("async_rst_cnt", d, 256'(ocnt[d]), 256'd0);
                    chk("async_rst_orphan", d, 256'(orph[d]), 256'd0);
                end
                model_reset();
                drive(2'b00, 1'b1, 1'b1, 1'b0);
                @(posedge clk);
                #3 rst_n = 1'b1;
                cyc();
            end else begin
                for (int d = 0; d < 2; d++) begin
                    for (int c = 0; c < 2; c++) begin
                        if (ch_vld[d][c] && m_last_g[d] == c) ch_vld[d][c] = 1'b0;
                        if (!ch_vld[d][c] && ($urandom % 10) < 4) begin
                            ch_vld[d][c] = 1'b1;
                            ch_info[d][c*REQ_W +: REQ_W] = rand_info();
                        end
                    end
                    mreq_rdy[d] = ($urandom % 10) < 7;
                    rsp_vld[d]  = (m_cnt[d] > 0 && ($urandom % 10) < 4) || ($urandom % 64) == 0;
                    rsp_err[d]  = ($urandom % 4) == 0;
                    rsp_dat[d]  = {$urandom, $urandom, $urandom, $urandom};
                end
                cyc();
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("post_rst_orphan", d, 256'(orph[d]), 256'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
